// File: rtl/gayle_ide_sector_ctrl.sv
// PIO sector-transfer sequencer for one Gayle IDE channel: owns the data FIFO
// strobes and steps through host/CPU fill and drain phases sector by sector.
module gayle_ide_sector_ctrl #(
    parameter int SECT_W = 9
) (
    input  logic        clk,
    input  logic        clk7_en,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_dir,
    input  logic [7:0]  cmd_count,
    input  logic        abort,
    input  logic        irq_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_din,
    input  logic        hst_rd,
    input  logic        hst_wr,
    input  logic [15:0] hst_din,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    input  logic        fifo_last_in,
    input  logic        fifo_last_out,
    output logic        fifo_rd,
    output logic        fifo_wr,
    output logic [15:0] fifo_din,
    output logic        bsy,
    output logic        drq,
    output logic        irq,
    output logic        hst_req,
    output logic        done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        IDLE, HOST_FILL, CPU_DRAIN, CPU_FILL, HOST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [SECT_W-1:0] sect_q, sect_d, sect_dec;
    logic              irq_q, irq_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic              cpu_rd_ok, hst_rd_ok;

    // Only the side that owns the current phase may touch the FIFO.
    assign cpu_rd_ok = (state_q == CPU_DRAIN)  && cpu_rd && !fifo_empty;
    assign hst_rd_ok = (state_q == HOST_DRAIN) && hst_rd && !fifo_empty;
    assign fifo_rd   = cpu_rd_ok || hst_rd_ok;
    assign fifo_wr   = ((state_q == HOST_FILL) && hst_wr) || ((state_q == CPU_FILL) && cpu_wr);
    assign fifo_din  = (state_q == HOST_FILL) ? hst_din : cpu_din;

    assign sect_dec  = (sect_q != '0) ? sect_q - SECT_W'(1) : '0;

    assign bsy      = (state_q == HOST_FILL) || (state_q == HOST_DRAIN);
    assign hst_req  = bsy;
    assign drq      = (state_q == CPU_DRAIN) || (state_q == CPU_FILL);
    assign irq      = irq_q;
    assign done     = done_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        sect_d     = sect_q;
        irq_d      = irq_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        if (irq_ack)
            irq_d = 1'b0;
        // Any set below overrides a same-cycle irq_ack.
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    sect_d     = (cmd_count == 8'd0) ? SECT_W'(256) : SECT_W'(cmd_count);
                    irq_d      = 1'b0;
                    underrun_d = 1'b0;
                    state_d    = cmd_dir ? CPU_FILL : HOST_FILL;
                end
            end
            HOST_FILL: begin
                if (fifo_full) begin
                    state_d = CPU_DRAIN;
                    irq_d   = 1'b1;
                end
            end
            CPU_DRAIN: begin
                if (cpu_rd && fifo_empty)
                    underrun_d = 1'b1;
                if (cpu_rd_ok && fifo_last_out) begin
                    sect_d = sect_dec;
                    if (sect_dec == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HOST_FILL;
                    end
                end
            end
            CPU_FILL: begin
                if (cpu_wr && fifo_last_in)
                    state_d = HOST_DRAIN;
            end
            HOST_DRAIN: begin
                if (hst_rd && fifo_empty)
                    underrun_d = 1'b1;
                if (hst_rd_ok && fifo_last_out) begin
                    sect_d = sect_dec;
                    irq_d  = 1'b1;
                    if (sect_dec == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CPU_FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            sect_d     = '0;
            done_d     = 1'b0;
            irq_d      = irq_q;
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sect_q     <= '0;
            irq_q      <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (clk7_en) begin
            state_q    <= state_d;
            sect_q     <= sect_d;
            irq_q      <= irq_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_gayle_ide_sector_ctrl.sv
// Directed bench for gayle_ide_sector_ctrl; the bench plays the FIFO status
// lines and both bus masters, and counts the enabled FIFO strobes itself.
module tb_gayle_ide_sector_ctrl;

    logic        clk = 1'b0;
    logic        clk7_en, reset, cmd_start, cmd_dir, abort, irq_ack;
    logic [7:0]  cmd_count;
    logic        cpu_rd, cpu_wr, hst_rd, hst_wr;
    logic [15:0] cpu_din, hst_din;
    logic        fifo_full, fifo_empty, fifo_last_in, fifo_last_out;
    logic        fifo_rd, fifo_wr;
    logic [15:0] fifo_din;
    logic        bsy, drq, irq, hst_req, done, underrun;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    gayle_ide_sector_ctrl #(.SECT_W(9)) dut (
        .clk(clk), .clk7_en(clk7_en), .reset(reset),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
        .abort(abort), .irq_ack(irq_ack),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .hst_rd(hst_rd), .hst_wr(hst_wr), .hst_din(hst_din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_last_in(fifo_last_in), .fifo_last_out(fifo_last_out),
        .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .bsy(bsy), .drq(drq), .irq(irq), .hst_req(hst_req),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Strobes count as FIFO accesses only on enabled cycles.
    always @(negedge clk) begin
        if (clk7_en && fifo_rd) rd_cnt++;
        if (clk7_en && fifo_wr) wr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_start = 0; cmd_dir = 0; cmd_count = 0; abort = 0; irq_ack = 0;
        cpu_rd = 0; cpu_wr = 0; hst_rd = 0; hst_wr = 0;
        cpu_din = 16'h0000; hst_din = 16'h0000;
        fifo_full = 0; fifo_empty = 0; fifo_last_in = 0; fifo_last_out = 0;
    endtask

    task automatic start_cmd(input logic dir, input logic [7:0] cnt);
        cmd_start = 1; cmd_dir = dir; cmd_count = cnt;
        step();
        cmd_start = 0;
    endtask

    // HOST_FILL -> CPU_DRAIN with a single write then fifo_full.
    task automatic quick_fill();
        hst_wr = 1; step(); hst_wr = 0;
        fifo_full = 1; step(); fifo_full = 0;
    endtask

    function automatic logic [5:0] outs();
        return {bsy, drq, irq, hst_req, done, underrun};
    endfunction

    task automatic test_reset();
        clear_inputs();
        clk7_en = 1; reset = 1;
        #2;
        checks++;
        if (outs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_init outs=%b expected=000000", outs());
        end
        step(); step();
        reset = 0;
        step();
        // Build CPU_DRAIN with 3 sectors and a sticky underrun, then reset asynchronously.
        start_cmd(1'b0, 8'd3);
        quick_fill();
        cpu_rd = 1; fifo_empty = 1; step(); cpu_rd = 0; fifo_empty = 0;
        checks++;
        if (outs() !== 6'b011001) begin
            failures++;
            $display("FAIL reset_pre outs=%b expected=011001", outs());
        end
        #2 reset = 1;
        #1;
        checks++;
        if (outs() !== 6'b0 || fifo_rd !== 1'b0 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_async outs=%b rd=%b wr=%b expected=000000 0 0", outs(), fifo_rd, fifo_wr);
        end
        step();
        reset = 0;
        step();
    endtask

    task automatic test_read();
        int rd0, wr0;
        logic din_ok;
        clear_inputs();
        rd0 = rd_cnt; wr0 = wr_cnt;
        din_ok = 1;
        start_cmd(1'b0, 8'd2);
        checks++;
        if ({bsy, hst_req, drq} !== 3'b110) begin
            failures++;
            $display("FAIL read_start bsy/hreq/drq=%b expected=110", {bsy, hst_req, drq});
        end
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 256; w++) begin
                hst_wr = 1; hst_din = 16'(w * 3 + s); cpu_din = 16'hDEAD;
                #1;
                if (fifo_din !== 16'(w * 3 + s)) din_ok = 0;
                step();
            end
            hst_wr = 0; fifo_full = 1; step(); fifo_full = 0;
            checks++;
            if ({drq, bsy, irq} !== 3'b101) begin
                failures++;
                $display("FAIL read_full%0d drq/bsy/irq=%b expected=101", s, {drq, bsy, irq});
            end
            for (int r = 0; r < 256; r++) begin
                cpu_rd = 1; fifo_last_out = (r == 255);
                step();
            end
            cpu_rd = 0; fifo_last_out = 0;
            if (s == 0) begin
                checks++;
                if ({bsy, drq, done} !== 3'b100) begin
                    failures++;
                    $display("FAIL read_sect0 bsy/drq/done=%b expected=100", {bsy, drq, done});
                end
            end
        end
        checks++;
        if ({done, bsy, drq} !== 3'b100) begin
            failures++;
            $display("FAIL read_done done/bsy/drq=%b expected=100", {done, bsy, drq});
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL read_done_pulse done=%b expected=0", done);
        end
        checks++;
        if (rd_cnt - rd0 != 512 || wr_cnt - wr0 != 512) begin
            failures++;
            $display("FAIL read_counts rd=%0d wr=%0d expected=512 512", rd_cnt - rd0, wr_cnt - wr0);
        end
        checks++;
        if (!din_ok) begin
            failures++;
            $display("FAIL read_din_mux saw=0 expected=1");
        end
    endtask

    task automatic test_write_256();
        int pairs = 0, irq_sets = 0, done_at = -1, bad = 0;
        clear_inputs();
        start_cmd(1'b1, 8'd0);
        for (int s = 0; s < 300 && done_at < 0; s++) begin
            if (drq !== 1'b1 || bsy !== 1'b0) bad++;
            cpu_wr = 1; fifo_last_in = 1; irq_ack = 1; cpu_din = 16'(s);
            #1;
            if (fifo_din !== 16'(s) || fifo_wr !== 1'b1) bad++;
            step();
            cpu_wr = 0; fifo_last_in = 0; irq_ack = 0;
            if (drq !== 1'b0 || bsy !== 1'b1 || irq !== 1'b0) bad++;
            hst_rd = 1; fifo_last_out = 1;
            step();
            hst_rd = 0; fifo_last_out = 0;
            pairs++;
            if (irq === 1'b1) irq_sets++;
            if (done === 1'b1) done_at = pairs;
        end
        checks++;
        if (pairs != 256 || done_at != 256) begin
            failures++;
            $display("FAIL write256_pairs pairs=%0d done_at=%0d expected=256 256", pairs, done_at);
        end
        checks++;
        if (irq_sets != 256) begin
            failures++;
            $display("FAIL write256_irq sets=%0d expected=256", irq_sets);
        end
        checks++;
        if (bad != 0 || bsy !== 1'b0 || drq !== 1'b0) begin
            failures++;
            $display("FAIL write256_phase bad=%0d bsy=%b drq=%b expected=0 0 0", bad, bsy, drq);
        end
        irq_ack = 1; step(); irq_ack = 0;
    endtask

    task automatic test_underrun_isolation();
        clear_inputs();
        start_cmd(1'b0, 8'd1);
        quick_fill();
        cpu_rd = 1; fifo_empty = 1; hst_wr = 1; cmd_start = 1; cmd_dir = 1;
        #1;
        checks++;
        if (fifo_rd !== 1'b0 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL underrun_strobes rd=%b wr=%b expected=0 0", fifo_rd, fifo_wr);
        end
        step();
        clear_inputs();
        checks++;
        if ({underrun, drq, bsy} !== 3'b110) begin
            failures++;
            $display("FAIL underrun_flag und/drq/bsy=%b expected=110", {underrun, drq, bsy});
        end
        abort = 1; step(); abort = 0;
        cpu_wr = 1; hst_wr = 1; cpu_rd = 1; hst_rd = 1;
        #1;
        checks++;
        if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0 || underrun !== 1'b1 || drq !== 1'b0) begin
            failures++;
            $display("FAIL idle_isolation wr=%b rd=%b und=%b drq=%b expected=0 0 1 0", fifo_wr, fifo_rd, underrun, drq);
        end
        step();
        clear_inputs();
        start_cmd(1'b0, 8'd1);
        checks++;
        if (underrun !== 1'b0 || bsy !== 1'b1) begin
            failures++;
            $display("FAIL underrun_clear und=%b bsy=%b expected=0 1", underrun, bsy);
        end
        abort = 1; step(); abort = 0;
    endtask

    task automatic test_abort_irq();
        clear_inputs();
        start_cmd(1'b0, 8'd1);
        hst_wr = 1; step(); hst_wr = 0;
        fifo_full = 1; irq_ack = 1; step(); fifo_full = 0; irq_ack = 0;
        checks++;
        if (irq !== 1'b1 || drq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_vs_ack irq=%b drq=%b expected=1 1", irq, drq);
        end
        abort = 1; step(); abort = 0;
        start_cmd(1'b1, 8'd3);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_cmd_clear irq=%b expected=0", irq);
        end
        cpu_wr = 1; fifo_last_in = 1; step(); cpu_wr = 0; fifo_last_in = 0;
        hst_rd = 1; fifo_last_out = 1; step(); hst_rd = 0; fifo_last_out = 0;
        cpu_wr = 1; fifo_last_in = 1; step(); cpu_wr = 0; fifo_last_in = 0;
        checks++;
        if ({bsy, hst_req, drq, irq} !== 4'b1101) begin
            failures++;
            $display("FAIL abort_pre bsy/hreq/drq/irq=%b expected=1101", {bsy, hst_req, drq, irq});
        end
        abort = 1; step(); abort = 0;
        checks++;
        if ({bsy, hst_req, drq, done, irq} !== 5'b00001) begin
            failures++;
            $display("FAIL abort_host_drain bsy/hreq/drq/done/irq=%b expected=00001", {bsy, hst_req, drq, done, irq});
        end
        irq_ack = 1; step(); irq_ack = 0;
        checks++;
        if (irq !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL irq_ack_clear irq=%b done=%b expected=0 0", irq, done);
        end
    endtask

    task automatic test_clk_en_stretch();
        int wr0;
        clear_inputs();
        wr0 = wr_cnt;
        clk7_en = 0;
        cmd_start = 1; cmd_dir = 0; cmd_count = 8'd1;
        step(); step(); step();
        checks++;
        if (bsy !== 1'b0) begin
            failures++;
            $display("FAIL en_hold_start bsy=%b expected=0", bsy);
        end
        clk7_en = 1; step(); cmd_start = 0;
        checks++;
        if (bsy !== 1'b1) begin
            failures++;
            $display("FAIL en_start bsy=%b expected=1", bsy);
        end
        hst_wr = 1;
        for (int i = 0; i < 8; i++) begin
            clk7_en = i[0];
            step();
        end
        hst_wr = 0; clk7_en = 0; fifo_full = 1;
        step(); step();
        checks++;
        if (drq !== 1'b0 || wr_cnt - wr0 != 4) begin
            failures++;
            $display("FAIL en_hold_full drq=%b writes=%0d expected=0 4", drq, wr_cnt - wr0);
        end
        clk7_en = 1; step(); fifo_full = 0;
        clk7_en = 0; cpu_rd = 1; fifo_last_out = 1;
        step(); step();
        checks++;
        if (drq !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL en_hold_drain drq=%b done=%b expected=1 0", drq, done);
        end
        clk7_en = 1; step(); cpu_rd = 0; fifo_last_out = 0;
        clk7_en = 0; step(); step();
        checks++;
        if (done !== 1'b1 || drq !== 1'b0) begin
            failures++;
            $display("FAIL en_done_hold done=%b drq=%b expected=1 0", done, drq);
        end
        clk7_en = 1; step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL en_done_clear done=%b expected=0", done);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_256();
        test_underrun_isolation();
        test_abort_irq();
        test_clk_en_stretch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
